// File: rtl/cpu_sequencer_pkg.sv
// Shared decode constants for cpu_sequencer: opcode values and instruction field positions.
package cpu_sequencer_pkg;

    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;
    localparam int R1_MSB     = 11;
    localparam int R1_LSB     = 10;
    localparam int R2_MSB     = 9;
    localparam int R2_LSB     = 8;
    localparam int IMM_MSB    = 7;
    localparam int IMM_LSB    = 0;

    localparam logic [3:0] OP_LOAD       = 4'd0;
    localparam logic [3:0] OP_JUMP       = 4'd1;
    localparam logic [3:0] OP_ADD        = 4'd2;
    localparam logic [3:0] OP_JUMPZERO   = 4'd3;
    localparam logic [3:0] OP_HALT       = 4'd5;
    localparam logic [3:0] OP_LOADSWITCH = 4'd7;
    localparam logic [3:0] OP_OUTPUT     = 4'd9;
    localparam logic [3:0] OP_INCREMENT  = 4'd11;
    localparam logic [3:0] OP_LSHIFT     = 4'd13;
    localparam logic [3:0] OP_DECREMENT  = 4'd14;
    localparam logic [3:0] OP_RSHIFT     = 4'd15;

    // Opcodes whose ALU result is written back to regs[r1].
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_LOAD)      || (op == OP_ADD)    ||
               (op == OP_LOADSWITCH) || (op == OP_INCREMENT) ||
               (op == OP_LSHIFT)    || (op == OP_DECREMENT) ||
               (op == OP_RSHIFT);
    endfunction

endpackage

// File: rtl/cpu_sequencer_register_file_4x8.sv
// Register file for cpu_sequencer: two combinational read ports, one synchronous write port.
module register_file_4x8 #(
    parameter int DATA_WIDTH = 8,
    parameter int IDX_WIDTH  = 2
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic [IDX_WIDTH-1:0]  rd_addr_a_i,
    input  logic [IDX_WIDTH-1:0]  rd_addr_b_i,
    output logic [DATA_WIDTH-1:0] rd_data_a_o,
    output logic [DATA_WIDTH-1:0] rd_data_b_o,
    input  logic                  wr_en_i,
    input  logic [IDX_WIDTH-1:0]  wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i
);

    localparam int DEPTH = 1 << IDX_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_a_o = regs_q[rd_addr_a_i];
    assign rd_data_b_o = regs_q[rd_addr_b_i];

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer around an external combinational ALU.
// Optional CPU_SEQUENCER_SINGLE_STEP_EN adds a `step` input gating each fetch.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_FETCH   | romAddress=pc; wait for run permission
// ST_DECODE  | ROM word for pc is valid; latch it into the instruction reg
// ST_EXECUTE | ALU fed from instruction reg; writeback / pc / led update
// ST_HALTED  | terminal until reset; halted=1
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int OPCODE_WIDTH      = 4,
    parameter int REGISTER_WIDTH    = 8,
    parameter int PC_WIDTH          = 8,
    parameter int INSTRUCTION_WIDTH = 16,
    parameter int NUM_REGISTERS     = 4
) (
    input  logic                         clock,
    input  logic                         resetN,
    input  logic                         enable,
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
    input  logic                         step,
`endif
    output logic [PC_WIDTH-1:0]          romAddress,
    input  logic [INSTRUCTION_WIDTH-1:0] romData,
    output logic [OPCODE_WIDTH-1:0]      opCode,
    output logic [REGISTER_WIDTH-1:0]    register1Value,
    output logic [REGISTER_WIDTH-1:0]    register2Value,
    output logic [REGISTER_WIDTH-1:0]    instructionValue,
    output logic                         switch,
    input  logic [REGISTER_WIDTH-1:0]    aluResult,
    input  logic                         switchIn,
    output logic [REGISTER_WIDTH-1:0]    ledOut,
    output logic                         halted
);

    localparam int IDX_WIDTH = $clog2(NUM_REGISTERS);

    localparam logic [1:0] ST_FETCH   = 2'd0;
    localparam logic [1:0] ST_DECODE  = 2'd1;
    localparam logic [1:0] ST_EXECUTE = 2'd2;
    localparam logic [1:0] ST_HALTED  = 2'd3;

    logic [1:0]                   state_q, state_d;
    logic [PC_WIDTH-1:0]          pc_q, pc_d;
    logic [INSTRUCTION_WIDTH-1:0] ir_q, ir_d;
    logic [REGISTER_WIDTH-1:0]    led_q, led_d;
    logic [1:0]                   switch_sync_q;
    logic                         advance;
    logic                         wr_en;

    logic [OPCODE_WIDTH-1:0]      op;
    logic [IDX_WIDTH-1:0]         r1_idx, r2_idx;
    logic [REGISTER_WIDTH-1:0]    imm;
    logic [REGISTER_WIDTH-1:0]    rd_a, rd_b;

`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
    // [1:0] synchronize the button, [2] remembers the previous synchronized level.
    logic [2:0] step_sync_q;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            step_sync_q <= '0;
        end else begin
            step_sync_q <= {step_sync_q[1:0], step};
        end
    end

    assign advance = enable & step_sync_q[1] & ~step_sync_q[2];
`else
    assign advance = enable;
`endif

    assign op     = ir_q[OPCODE_MSB:OPCODE_LSB];
    assign r1_idx = ir_q[R1_MSB:R1_LSB];
    assign r2_idx = ir_q[R2_MSB:R2_LSB];
    assign imm    = ir_q[IMM_MSB:IMM_LSB];

    register_file_4x8 #(
        .DATA_WIDTH (REGISTER_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_regs (
        .clock_i     (clock),
        .reset_n_i   (resetN),
        .rd_addr_a_i (r1_idx),
        .rd_addr_b_i (r2_idx),
        .rd_data_a_o (rd_a),
        .rd_data_b_o (rd_b),
        .wr_en_i     (wr_en),
        .wr_addr_i   (r1_idx),
        .wr_data_i   (aluResult)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        led_d   = led_q;
        wr_en   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (advance) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ir_d    = romData;
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                state_d = ST_FETCH;
                pc_d    = pc_q + PC_WIDTH'(1);
                if (is_alu_op(op)) begin
                    wr_en = 1'b1;
                end else if (op == OP_JUMP) begin
                    pc_d = PC_WIDTH'(imm);
                end else if (op == OP_JUMPZERO) begin
                    if (rd_a == '0) pc_d = PC_WIDTH'(imm);
                end else if (op == OP_OUTPUT) begin
                    led_d = rd_a;
                end else if (op == OP_HALT) begin
                    pc_d    = pc_q;
                    state_d = ST_HALTED;
                end
            end
            default: begin
                state_d = ST_HALTED;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q       <= ST_FETCH;
            pc_q          <= '0;
            ir_q          <= '0;
            led_q         <= '0;
            switch_sync_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            led_q         <= led_d;
            switch_sync_q <= {switch_sync_q[0], switchIn};
        end
    end

    assign romAddress       = pc_q;
    assign opCode           = op;
    assign register1Value   = rd_a;
    assign register2Value   = rd_b;
    assign instructionValue = imm;
    assign switch           = switch_sync_q[1];
    assign ledOut           = led_q;
    assign halted           = (state_q == ST_HALTED);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios plus random programs
// checked against an instruction-level reference model.
module tb_cpu_sequencer;

    logic        clock;
    logic        resetN;
    logic        enable;
    logic [7:0]  romAddress;
    logic [15:0] romData;
    logic [3:0]  opCode;
    logic [7:0]  register1Value;
    logic [7:0]  register2Value;
    logic [7:0]  instructionValue;
    logic        switch;
    logic [7:0]  aluResult;
    logic        switchIn;
    logic [7:0]  ledOut;
    logic        halted;
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
    logic        step;
`endif

    logic [15:0] rom [256];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] m_regs [4];
    logic [7:0] m_pc;
    logic [7:0] m_led;
    logic       m_halted;
    logic       m_sw;

    cpu_sequencer dut (
        .clock            (clock),
        .resetN           (resetN),
        .enable           (enable),
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
        .step             (step),
`endif
        .romAddress       (romAddress),
        .romData          (romData),
        .opCode           (opCode),
        .register1Value   (register1Value),
        .register2Value   (register2Value),
        .instructionValue (instructionValue),
        .switch           (switch),
        .aluResult        (aluResult),
        .switchIn         (switchIn),
        .ledOut           (ledOut),
        .halted           (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) romData <= rom[romAddress];

    function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [7:0] imm,
                                          input logic sw);
        case (op)
            4'd0:    return imm;
            4'd2:    return a + b;
            4'd7:    return {7'd0, sw};
            4'd11:   return a + 8'd1;
            4'd13:   return {a[6:0], 1'b0};
            4'd14:   return a - 8'd1;
            4'd15:   return {1'b0, a[7:1]};
            default: return 8'h00;
        endcase
    endfunction

    assign aluResult = alu_fn(opCode, register1Value, register2Value, instructionValue, switch);

    function automatic logic [15:0] enc(input int op, input int r1, input int r2, input int imm);
        logic [15:0] w;
        w[15:12] = op[3:0];
        w[11:10] = r1[1:0];
        w[9:8]   = r2[1:0];
        w[7:0]   = imm[7:0];
        return w;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic fill_rom(input logic [15:0] w);
        for (int i = 0; i < 256; i++) rom[i] = w;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        enable = 1'b0;
        tick(2);
        resetN = 1'b1;
    endtask

    // Executes one whole instruction at the architectural level.
    task automatic model_step();
        logic [15:0] w;
        logic [3:0]  op;
        logic [1:0]  r1, r2;
        logic [7:0]  imm;
        w   = rom[m_pc];
        op  = w[15:12];
        r1  = w[11:10];
        r2  = w[9:8];
        imm = w[7:0];
        case (op)
            4'd0, 4'd2, 4'd7, 4'd11, 4'd13, 4'd14, 4'd15: begin
                m_regs[r1] = alu_fn(op, m_regs[r1], m_regs[r2], imm, m_sw);
                m_pc = m_pc + 8'd1;
            end
            4'd1: m_pc = imm;
            4'd3: m_pc = (m_regs[r1] == 8'd0) ? imm : m_pc + 8'd1;
            4'd5: m_halted = 1'b1;
            4'd9: begin
                m_led = m_regs[r1];
                m_pc  = m_pc + 8'd1;
            end
            default: m_pc = m_pc + 8'd1;
        endcase
    endtask

    initial begin
        logic [15:0] w;
        logic [15:0] cur;
        int          idle;

        resetN   = 1'b0;
        enable   = 1'b0;
        switchIn = 1'b0;
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
        step     = 1'b0;
`endif
        fill_rom(enc(6, 0, 0, 0));

        // Reset state, then enable low holds FETCH
        rom[0] = enc(0, 1, 2, 8'h5A);
        do_reset();
        check("rst_romAddress", 16'(romAddress), 16'h0);
        check("rst_ledOut", 16'(ledOut), 16'h0);
        check("rst_halted", 16'(halted), 16'h0);
        check("rst_switch", 16'(switch), 16'h0);
        check("rst_opCode", 16'(opCode), 16'h0);
        tick(10);
        check("idle_romAddress", 16'(romAddress), 16'h0);
        check("idle_no_decode", 16'(instructionValue), 16'h0);

`ifndef CPU_SEQUENCER_SINGLE_STEP_EN
        // Enable drops after the fetch: instruction still completes, then waits
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
        tick(2);
        check("drop_retire_pc", 16'(romAddress), 16'h1);
        tick(5);
        check("drop_hold_pc", 16'(romAddress), 16'h1);

        // Program: 5 + 3 -> led, then halt
        fill_rom(enc(6, 0, 0, 0));
        rom[0] = enc(0, 0, 0, 5);
        rom[1] = enc(0, 1, 0, 3);
        rom[2] = enc(2, 0, 1, 0);
        rom[3] = enc(9, 0, 0, 0);
        rom[4] = enc(5, 0, 0, 0);
        do_reset();
        enable = 1'b1;
        tick(12);
        check("add_ledOut", 16'(ledOut), 16'd8);
        tick(2);
        check("halt_not_yet", 16'(halted), 16'h0);
        tick(1);
        check("halt_at_15", 16'(halted), 16'h1);
        check("halt_pc", 16'(romAddress), 16'h4);
        tick(6);
        check("halt_sticky", 16'(halted), 16'h1);
        check("halt_pc_sticky", 16'(romAddress), 16'h4);

        // JUMPZERO taken and not taken
        fill_rom(enc(6, 0, 0, 0));
        rom[8'h00] = enc(0, 2, 0, 0);
        rom[8'h01] = enc(3, 2, 0, 8'h20);
        rom[8'h20] = enc(0, 2, 0, 1);
        rom[8'h21] = enc(3, 2, 0, 8'h40);
        do_reset();
        enable = 1'b1;
        tick(6);
        check("jz_taken", 16'(romAddress), 16'h20);
        tick(6);
        check("jz_not_taken", 16'(romAddress), 16'h22);

        // Switch synchronizer latency and LOADSWITCH
        fill_rom(enc(6, 0, 0, 0));
        rom[0] = enc(7, 3, 0, 0);
        rom[1] = enc(9, 3, 0, 0);
        do_reset();
        switchIn = 1'b1;
        tick(1);
        check("sw_lag1", 16'(switch), 16'h0);
        tick(1);
        check("sw_lag2", 16'(switch), 16'h1);
        enable = 1'b1;
        tick(6);
        check("loadswitch_led", 16'(ledOut), 16'h1);
        switchIn = 1'b0;

        // pc wrap 0xFF -> 0x00
        fill_rom(enc(6, 0, 0, 0));
        rom[8'h00] = enc(1, 0, 0, 8'hFF);
        rom[8'hFF] = enc(11, 0, 0, 0);
        do_reset();
        enable = 1'b1;
        tick(3);
        check("jump_ff", 16'(romAddress), 16'hFF);
        tick(3);
        check("pc_wrap", 16'(romAddress), 16'h00);

        // Reset during EXECUTE of ADD aborts writeback
        fill_rom(enc(6, 0, 0, 0));
        rom[0] = enc(0, 0, 0, 5);
        rom[1] = enc(9, 0, 0, 0);
        rom[2] = enc(0, 1, 0, 3);
        rom[3] = enc(2, 0, 1, 0);
        do_reset();
        enable = 1'b1;
        tick(6);
        check("pre_rst_led", 16'(ledOut), 16'd5);
        tick(5);
        check("exec_add_op", 16'(opCode), 16'd2);
        check("exec_add_r1", 16'(register1Value), 16'd5);
        check("exec_add_r2", 16'(register2Value), 16'd3);
        #2;
        resetN = 1'b0;
        #1;
        check("async_rst_pc", 16'(romAddress), 16'h0);
        check("async_rst_led", 16'(ledOut), 16'h0);
        check("async_rst_r1", 16'(register1Value), 16'h0);
        check("async_rst_r2", 16'(register2Value), 16'h0);
        rom[0] = enc(9, 0, 0, 0);
        rom[1] = enc(9, 1, 0, 0);
        enable = 1'b0;
        tick(1);
        resetN = 1'b1;
        tick(1);
        check("post_rst_fetch", 16'(romAddress), 16'h0);
        enable = 1'b1;
        tick(3);
        check("no_wb_r0", 16'(ledOut), 16'h0);
        check("post_rst_pc", 16'(romAddress), 16'h1);

        // Random programs against the instruction-level model
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 256; i++) begin
                w = 16'($urandom);
                if (w[15:12] == 4'd5 && $urandom_range(0, 3) != 0) w[15:12] = 4'd6;
                rom[i] = w;
            end
            do_reset();
            switchIn = 1'($urandom_range(0, 1));
            tick(3);
            for (int r = 0; r < 4; r++) m_regs[r] = 8'd0;
            m_pc     = 8'd0;
            m_led    = 8'd0;
            m_halted = 1'b0;
            m_sw     = switchIn;
            for (int k = 0; k < 30; k++) begin
                if (m_halted) begin
                    tick(3);
                    check("rnd_halted_sticky", 16'(halted), 16'h1);
                    check("rnd_halted_pc", 16'(romAddress), 16'(m_pc));
                    break;
                end
                idle = $urandom_range(0, 2);
                if (idle > 0) begin
                    enable = 1'b0;
                    tick(idle);
                    check("rnd_idle_pc", 16'(romAddress), 16'(m_pc));
                end
                enable = 1'b1;
                tick(2);
                cur = rom[m_pc];
                check("rnd_opCode", 16'(opCode), 16'(cur[15:12]));
                check("rnd_imm", 16'(instructionValue), 16'(cur[7:0]));
                check("rnd_reg1", 16'(register1Value), 16'(m_regs[cur[11:10]]));
                check("rnd_reg2", 16'(register2Value), 16'(m_regs[cur[9:8]]));
                enable = 1'($urandom_range(0, 1));
                tick(1);
                model_step();
                check("rnd_pc", 16'(romAddress), 16'(m_pc));
                check("rnd_led", 16'(ledOut), 16'(m_led));
                check("rnd_halted", 16'(halted), 16'(m_halted));
            end
        end
`else
        // Single step: each synchronized rising edge of step retires one instruction
        fill_rom(enc(6, 0, 0, 0));
        do_reset();
        enable = 1'b1;
        tick(5);
        check("step_none", 16'(romAddress), 16'h0);
        step = 1'b1;
        tick(10);
        check("step_one", 16'(romAddress), 16'h1);
        step = 1'b0;
        tick(3);
        step = 1'b1;
        tick(10);
        check("step_two", 16'(romAddress), 16'h2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
